// File: rtl/lsu_mem_master.sv
// Load/store initiator between the MEM stage and the doubleword data memory port.
// Define LSU_PERF_CNT_EN to add load/store/misalign/stall performance counters.
module lsu_mem_master #(
   parameter int unsigned MEM_LATENCY = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_misalign,
   output logic [63:0] mem_raddr,
   output logic [63:0] mem_waddr,
   output logic [63:0] mem_wdata,
   output logic [7:0]  mem_wmask,
   output logic        mem_read_en,
   output logic        mem_write_en,
   input  logic [63:0] mem_rdata
`ifdef LSU_PERF_CNT_EN
   ,
   output logic [31:0] perf_loads,
   output logic [31:0] perf_stores,
   output logic [31:0] perf_misalign,
   output logic [31:0] perf_stall
`endif
);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_e;

   localparam logic [3:0] LAT = 4'(MEM_LATENCY);

   state_e      state_q, state_d;
   logic        wen_q, uns_q, mis_q;
   logic [63:0] addr_q, wdata_q, rdata_q;
   logic [1:0]  size_q;
   logic [3:0]  cnt_q;

   logic        accept, misalign_req, sample;
   logic [2:0]  off;
   logic [63:0] aligned_addr, lane, load_ext;
   logic [7:0]  size_mask;

   assign accept       = (state_q == IDLE) && req_valid;
   assign off          = addr_q[2:0];
   assign aligned_addr = {addr_q[63:3], 3'b000};
   assign sample       = ((state_q == ACCESS) && (LAT == 4'd0)) ||
                         ((state_q == WAIT) && (cnt_q == 4'd1));

   always_comb begin
      misalign_req = 1'b0;
      case (req_size)
         2'd1:    misalign_req = req_addr[0];
         2'd2:    misalign_req = |req_addr[1:0];
         2'd3:    misalign_req = |req_addr[2:0];
         default: misalign_req = 1'b0;
      endcase
   end

   // Pick the addressed lane out of the doubleword, then extend to 64 bits.
   always_comb begin
      lane     = mem_rdata >> {off, 3'b000};
      load_ext = lane;
      case (size_q)
         2'd0:    load_ext = uns_q ? {56'd0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
         2'd1:    load_ext = uns_q ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
         2'd2:    load_ext = uns_q ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
         default: load_ext = lane;
      endcase
   end

   always_comb begin
      size_mask = 8'hFF;
      case (size_q)
         2'd0:    size_mask = 8'h01;
         2'd1:    size_mask = 8'h03;
         2'd2:    size_mask = 8'h0F;
         default: size_mask = 8'hFF;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_valid) state_d = misalign_req ? RESP : ACCESS;
         ACCESS:  state_d = (LAT == 4'd0) ? RESP : WAIT;
         WAIT:    if (cnt_q == 4'd1) state_d = RESP;
         RESP:    if (resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready     = (state_q == IDLE);
      resp_valid    = (state_q == RESP);
      resp_rdata    = resp_valid ? rdata_q : 64'd0;
      resp_misalign = resp_valid && mis_q;
      mem_read_en   = !wen_q && ((state_q == ACCESS) || (state_q == WAIT));
      mem_write_en  = wen_q && (state_q == ACCESS);
      mem_raddr     = mem_read_en  ? aligned_addr : 64'd0;
      mem_waddr     = mem_write_en ? aligned_addr : 64'd0;
      mem_wdata     = mem_write_en ? (wdata_q << {off, 3'b000}) : 64'd0;
      mem_wmask     = mem_write_en ? (size_mask << off) : 8'd0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wen_q   <= 1'b0;
         uns_q   <= 1'b0;
         mis_q   <= 1'b0;
         addr_q  <= 64'd0;
         wdata_q <= 64'd0;
         size_q  <= 2'd0;
         rdata_q <= 64'd0;
         cnt_q   <= 4'd0;
      end else begin
         if (accept) begin
            wen_q   <= req_wen;
            uns_q   <= req_unsigned;
            mis_q   <= misalign_req;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            size_q  <= req_size;
            rdata_q <= 64'd0;
         end
         if (state_q == ACCESS)    cnt_q <= LAT;
         else if (state_q == WAIT) cnt_q <= cnt_q - 4'd1;
         // Stores keep the zero loaded at accept.
         if (sample && !wen_q) rdata_q <= load_ext;
      end
   end

`ifdef LSU_PERF_CNT_EN
   logic [31:0] perf_loads_q, perf_stores_q, perf_misalign_q, perf_stall_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         perf_loads_q    <= 32'd0;
         perf_stores_q   <= 32'd0;
         perf_misalign_q <= 32'd0;
         perf_stall_q    <= 32'd0;
      end else begin
         if (accept && !misalign_req &&  req_wen) perf_stores_q   <= perf_stores_q + 32'd1;
         if (accept && !misalign_req && !req_wen) perf_loads_q    <= perf_loads_q + 32'd1;
         if (accept &&  misalign_req)             perf_misalign_q <= perf_misalign_q + 32'd1;
         if ((state_q == RESP) && !resp_ready)    perf_stall_q    <= perf_stall_q + 32'd1;
      end
   end

   assign perf_loads    = perf_loads_q;
   assign perf_stores   = perf_stores_q;
   assign perf_misalign = perf_misalign_q;
   assign perf_stall    = perf_stall_q;
`endif

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: instance 0 at MEM_LATENCY=0, instance 1 at MEM_LATENCY=3,
// each against a byte-level reference memory.
module tb_lsu_mem_master;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset [2];
   logic        req_valid [2], req_ready [2], req_wen [2], req_unsigned [2];
   logic [63:0] req_addr [2], req_wdata [2];
   logic [1:0]  req_size [2];
   logic        resp_valid [2], resp_ready [2], resp_misalign [2];
   logic [63:0] resp_rdata [2];
   logic [63:0] mem_raddr [2], mem_waddr [2], mem_wdata [2], mem_rdata [2];
   logic [7:0]  mem_wmask [2];
   logic        mem_read_en [2], mem_write_en [2];
`ifdef LSU_PERF_CNT_EN
   logic [31:0] perf_loads [2], perf_stores [2], perf_misalign [2], perf_stall [2];
`endif

   logic [63:0] tbmem [2][64] = '{default: '0};
   logic [7:0]  refm [2][512] = '{default: '0};
   logic        pk_en = 1'b0;
   int          pk_k = 0;
   logic [5:0]  pk_idx = '0;
   logic [63:0] pk_val = '0;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      lsu_mem_master #(.MEM_LATENCY(g == 0 ? 0 : 3)) dut (
         .clock(clock), .reset(reset[g]),
         .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_wen(req_wen[g]),
         .req_addr(req_addr[g]), .req_wdata(req_wdata[g]), .req_size(req_size[g]),
         .req_unsigned(req_unsigned[g]),
         .resp_valid(resp_valid[g]), .resp_ready(resp_ready[g]),
         .resp_rdata(resp_rdata[g]), .resp_misalign(resp_misalign[g]),
         .mem_raddr(mem_raddr[g]), .mem_waddr(mem_waddr[g]), .mem_wdata(mem_wdata[g]),
         .mem_wmask(mem_wmask[g]), .mem_read_en(mem_read_en[g]),
         .mem_write_en(mem_write_en[g]), .mem_rdata(mem_rdata[g])
`ifdef LSU_PERF_CNT_EN
         , .perf_loads(perf_loads[g]), .perf_stores(perf_stores[g]),
         .perf_misalign(perf_misalign[g]), .perf_stall(perf_stall[g])
`endif
      );
      assign mem_rdata[g] = mem_read_en[g] ? tbmem[g][mem_raddr[g][8:3]] : 64'd0;
   end

   // Memory model: 512-byte window, address bits above 8 alias.
   always @(posedge clock) begin
      if (pk_en) tbmem[pk_k][pk_idx] <= pk_val;
      for (int k = 0; k < 2; k++)
         if (mem_write_en[k])
            for (int b = 0; b < 8; b++)
               if (mem_wmask[k][b]) tbmem[k][mem_waddr[k][8:3]][8*b +: 8] <= mem_wdata[k][8*b +: 8];
   end

   int n_chk = 0, n_fail = 0, cur = 0;
   int o_cyc, o_nrd, o_nwr;
   logic o_both, o_mis;
   logic [63:0] o_rd, s_raddr, s_waddr, s_wdata;
   logic [7:0]  s_mask;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (item %0d): got %h expected %h", nm, cur, act, exp);
      end
   endtask

   function automatic logic is_mis(logic [63:0] a, logic [1:0] sz);
      return (int'(a[2:0]) % (1 << sz)) != 0;
   endfunction

   function automatic logic [63:0] ref_load(int k, logic [63:0] a, logic [1:0] sz, logic u);
      int n;
      logic [63:0] v;
      n = 1 << sz;
      v = 64'd0;
      for (int i = 0; i < n; i++) v = v | (64'(refm[k][int'(a[8:0]) + i]) << (8 * i));
      if (!u && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
      return v;
   endfunction

   task automatic apply_store(input int k, input logic [63:0] a, input logic [63:0] wd, input logic [1:0] sz);
      for (int i = 0; i < (1 << sz); i++) refm[k][int'(a[8:0]) + i] = wd[8*i +: 8];
   endtask

   task automatic poke(input int k, input logic [63:0] a, input logic [63:0] v);
      @(negedge clock);
      pk_en = 1'b1; pk_k = k; pk_idx = a[8:3]; pk_val = v;
      @(posedge clock);
      #1 pk_en = 1'b0;
      for (int i = 0; i < 8; i++) refm[k][int'({a[8:3], 3'b000}) + i] = v[8*i +: 8];
   endtask

   task automatic chk_reset_outs(input int k);
      chk("rst_req_ready", req_ready[k], 1'b1);
      chk("rst_resp_valid", resp_valid[k], 1'b0);
      chk("rst_resp_mis", resp_misalign[k], 1'b0);
      chk("rst_resp_rdata", resp_rdata[k], 64'd0);
      chk("rst_read_en", mem_read_en[k], 1'b0);
      chk("rst_write_en", mem_write_en[k], 1'b0);
      chk("rst_raddr", mem_raddr[k], 64'd0);
      chk("rst_waddr", mem_waddr[k], 64'd0);
      chk("rst_wdata", mem_wdata[k], 64'd0);
      chk("rst_wmask", mem_wmask[k], 8'd0);
`ifdef LSU_PERF_CNT_EN
      chk("rst_perf_loads", perf_loads[k], 64'd0);
      chk("rst_perf_stores", perf_stores[k], 64'd0);
      chk("rst_perf_mis", perf_misalign[k], 64'd0);
      chk("rst_perf_stall", perf_stall[k], 64'd0);
`endif
   endtask

   // One request through the handshake; ACCESS-cycle outputs and enable counts land in o_*/s_*.
   task automatic xact(input int k, input logic w, input logic [63:0] a, input logic [63:0] wd,
                       input logic [1:0] sz, input logic u, input int hold);
`ifdef LSU_PERF_CNT_EN
      logic [31:0] pl, ps, pm, pst;
      logic m;
`endif
      @(negedge clock);
      chk("req_ready_idle", req_ready[k], 1'b1);
`ifdef LSU_PERF_CNT_EN
      pl = perf_loads[k]; ps = perf_stores[k]; pm = perf_misalign[k]; pst = perf_stall[k];
`endif
      req_valid[k] = 1'b1; req_wen[k] = w; req_addr[k] = a; req_wdata[k] = wd;
      req_size[k] = sz; req_unsigned[k] = u;
      @(negedge clock);
      req_valid[k] = 1'b0;
      o_cyc = 1; o_nrd = 0; o_nwr = 0; o_both = 1'b0;
      s_raddr = mem_raddr[k]; s_waddr = mem_waddr[k]; s_wdata = mem_wdata[k]; s_mask = mem_wmask[k];
      while (1) begin
         if (mem_read_en[k]) o_nrd++;
         if (mem_write_en[k]) o_nwr++;
         if (mem_read_en[k] && mem_write_en[k]) o_both = 1'b1;
         if (resp_valid[k]) break;
         if (o_cyc >= 40) begin
            n_chk++; n_fail++;
            $display("FAIL resp_timeout (item %0d): no resp_valid after %0d cycles", cur, o_cyc);
            break;
         end
         chk("req_ready_busy", req_ready[k], 1'b0);
         @(negedge clock);
         o_cyc++;
      end
      o_rd = resp_rdata[k]; o_mis = resp_misalign[k];
      for (int i = 0; i < hold; i++) begin
         @(negedge clock);
         chk("hold_resp_valid", resp_valid[k], 1'b1);
         chk("hold_resp_rdata", resp_rdata[k], o_rd);
         chk("hold_resp_mis", resp_misalign[k], o_mis);
         chk("hold_req_ready", req_ready[k], 1'b0);
      end
`ifdef LSU_PERF_CNT_EN
      m = is_mis(a, sz);
      chk("perf_stall", perf_stall[k] - pst, 64'(hold));
      chk("perf_loads", perf_loads[k] - pl, !m && !w);
      chk("perf_stores", perf_stores[k] - ps, !m && w);
      chk("perf_mis", perf_misalign[k] - pm, m);
`endif
      resp_ready[k] = 1'b1;
      @(negedge clock);
      resp_ready[k] = 1'b0;
      chk("resp_valid_after_hs", resp_valid[k], 1'b0);
   endtask

   task automatic model_check(input int k, input logic w, input logic [63:0] a, input logic [63:0] wd,
                              input logic [1:0] sz, input logic u);
      logic m;
      int lat, n;
      logic [7:0] em;
      logic [63:0] ew, bm;
      m = is_mis(a, sz); lat = (k == 0) ? 0 : 3; n = 1 << sz;
      chk("m_rdata", o_rd, (m || w) ? 64'd0 : ref_load(k, a, sz, u));
      chk("m_mis", o_mis, m);
      chk("m_latency", o_cyc, m ? 1 : 2 + lat);
      chk("m_nread", o_nrd, (!m && !w) ? 1 + lat : 0);
      chk("m_nwrite", o_nwr, (!m && w) ? 1 : 0);
      chk("m_both_en", o_both, 1'b0);
      if (!m && !w) chk("m_raddr", s_raddr, a & ~64'd7);
      if (!m && w) begin
         em = 8'd0; ew = 64'd0; bm = 64'd0;
         for (int i = 0; i < n; i++) begin
            em[int'(a[2:0]) + i] = 1'b1;
            bm[8*(int'(a[2:0]) + i) +: 8] = 8'hFF;
            ew[8*(int'(a[2:0]) + i) +: 8] = wd[8*i +: 8];
         end
         chk("m_waddr", s_waddr, a & ~64'd7);
         chk("m_wmask", s_mask, em);
         chk("m_wdata", s_wdata & bm, ew);
         apply_store(k, a, wd, sz);
      end
   endtask

   typedef struct {
      logic w; logic [63:0] a; logic [63:0] wd; logic [1:0] sz; logic u;
      logic pre_en; logic [63:0] pre;
      logic [63:0] e_rd; logic e_mis; logic [7:0] e_mask; logic [63:0] e_wdata; logic [63:0] e_addr;
   } vec_t;

   vec_t tv [15];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tv[0]  = '{1, 64'h8000_0005, 64'hAB, 0, 0, 0, 0, 0, 0, 8'h20, 64'h0000_AB00_0000_0000, 64'h8000_0000};
      tv[1]  = '{0, 64'h8000_0006, 0, 1, 0, 1, 64'h8123_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8123, 0, 0, 0, 64'h8000_0000};
      tv[2]  = '{0, 64'h8000_0006, 0, 1, 1, 0, 0, 64'h0000_0000_0000_8123, 0, 0, 0, 64'h8000_0000};
      tv[3]  = '{0, 64'h8000_0004, 0, 2, 1, 1, 64'hDEAD_BEEF_1234_5678, 64'h0000_0000_DEAD_BEEF, 0, 0, 0, 64'h8000_0000};
      tv[4]  = '{0, 64'h8000_0000, 0, 3, 0, 0, 0, 64'hDEAD_BEEF_1234_5678, 0, 0, 0, 64'h8000_0000};
      tv[5]  = '{0, 64'h8000_0004, 0, 3, 0, 0, 0, 64'd0, 1, 0, 0, 0};
      tv[6]  = '{0, 64'h8000_0007, 0, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFDE, 0, 0, 0, 64'h8000_0000};
      tv[7]  = '{0, 64'h8000_0000, 0, 2, 0, 0, 0, 64'h0000_0000_1234_5678, 0, 0, 0, 64'h8000_0000};
      tv[8]  = '{0, 64'h8000_0004, 0, 2, 0, 0, 0, 64'hFFFF_FFFF_DEAD_BEEF, 0, 0, 0, 64'h8000_0000};
      tv[9]  = '{0, 64'h8000_0003, 0, 1, 0, 0, 0, 64'd0, 1, 0, 0, 0};
      tv[10] = '{1, 64'h8000_0002, 64'h1234_5678_9ABC_DEF0, 1, 0, 0, 0, 0, 0, 8'h0C, 64'h5678_9ABC_DEF0_0000, 64'h8000_0000};
      tv[11] = '{0, 64'hFFFF_FFFF_FFFF_FFF8, 0, 3, 0, 1, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFF8};
      tv[12] = '{1, 64'hFFFF_FFFF_FFFF_FFF8, 64'hCAFE_F00D_0BAD_BEEF, 3, 0, 0, 0, 0, 0, 8'hFF, 64'hCAFE_F00D_0BAD_BEEF, 64'hFFFF_FFFF_FFFF_FFF8};
      tv[13] = '{0, 64'h8000_0010, 0, 3, 1, 1, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 0, 0, 0, 64'h8000_0010};
      tv[14] = '{1, 64'h8000_000C, 64'hFFFF_FFFF_1122_3344, 2, 0, 0, 0, 0, 0, 8'hF0, 64'h1122_3344_0000_0000, 64'h8000_0008};

      for (int k = 0; k < 2; k++) begin
         reset[k] = 1'b1; req_valid[k] = 1'b0; req_wen[k] = 1'b0; req_addr[k] = '0;
         req_wdata[k] = '0; req_size[k] = '0; req_unsigned[k] = 1'b0; resp_ready[k] = 1'b0;
      end
      repeat (3) @(negedge clock);
      chk_reset_outs(0);
      chk_reset_outs(1);
      reset[0] = 1'b0; reset[1] = 1'b0;

      // Directed vectors on the zero-latency instance.
      for (int i = 0; i < 15; i++) begin
         cur = i;
         if (tv[i].pre_en) poke(0, tv[i].a, tv[i].pre);
         xact(0, tv[i].w, tv[i].a, tv[i].wd, tv[i].sz, tv[i].u, i % 3);
         chk("t_rdata", o_rd, tv[i].e_rd);
         chk("t_mis", o_mis, tv[i].e_mis);
         chk("t_latency", o_cyc, tv[i].e_mis ? 1 : 2);
         chk("t_nread", o_nrd, (!tv[i].e_mis && !tv[i].w) ? 1 : 0);
         chk("t_nwrite", o_nwr, (!tv[i].e_mis && tv[i].w) ? 1 : 0);
         if (!tv[i].e_mis && tv[i].w) begin
            chk("t_wmask", s_mask, tv[i].e_mask);
            chk("t_wdata", s_wdata, tv[i].e_wdata);
            chk("t_waddr", s_waddr, tv[i].e_addr);
            apply_store(0, tv[i].a, tv[i].wd, tv[i].sz);
         end else if (!tv[i].e_mis) begin
            chk("t_raddr", s_raddr, tv[i].e_addr);
         end
      end

      // Latency 3 load with the consumer stalling for five cycles.
      cur = 100;
      poke(1, 64'h8000_0040, 64'h8765_4321_0FED_CBA9);
      xact(1, 1'b0, 64'h8000_0040, 64'd0, 2'd3, 1'b0, 5);
      model_check(1, 1'b0, 64'h8000_0040, 64'd0, 2'd3, 1'b0);

      // Reset while a store sits in WAIT: it already wrote, and nothing more is issued.
      cur = 101;
      @(negedge clock);
      req_valid[1] = 1'b1; req_wen[1] = 1'b1; req_addr[1] = 64'h100;
      req_wdata[1] = 64'h5555_AAAA_3333_CCCC; req_size[1] = 2'd3;
      @(negedge clock);
      req_valid[1] = 1'b0;
      chk("rw_access_wen", mem_write_en[1], 1'b1);
      @(negedge clock);
      chk("rw_wait_wen", mem_write_en[1], 1'b0);
      chk("rw_wait_ready", req_ready[1], 1'b0);
      reset[1] = 1'b1;
      @(negedge clock);
      chk_reset_outs(1);
      reset[1] = 1'b0;
      o_nwr = 0; o_nrd = 0;
      repeat (6) begin
         @(negedge clock);
         if (mem_write_en[1]) o_nwr++;
         if (resp_valid[1]) o_nrd++;
      end
      chk("rw_no_more_writes", o_nwr, 0);
      chk("rw_no_resp", o_nrd, 0);
      apply_store(1, 64'h100, 64'h5555_AAAA_3333_CCCC, 2'd3);
      xact(1, 1'b0, 64'h100, 64'd0, 2'd3, 1'b0, 0);
      model_check(1, 1'b0, 64'h100, 64'd0, 2'd3, 1'b0);

      // Reset arriving with the request: the store is never issued.
      cur = 102;
      @(negedge clock);
      req_valid[1] = 1'b1; req_wen[1] = 1'b1; req_addr[1] = 64'h100;
      req_wdata[1] = 64'h0; req_size[1] = 2'd3; reset[1] = 1'b1;
      @(negedge clock);
      req_valid[1] = 1'b0; reset[1] = 1'b0;
      chk_reset_outs(1);
      o_nwr = 0;
      repeat (5) begin
         @(negedge clock);
         if (mem_write_en[1]) o_nwr++;
      end
      chk("rr_no_write", o_nwr, 0);
      xact(1, 1'b0, 64'h104, 64'd0, 2'd2, 1'b1, 0);
      model_check(1, 1'b0, 64'h104, 64'd0, 2'd2, 1'b1);

      // Randomized traffic against the byte-level reference.
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 80; i++) begin
            logic w, u;
            logic [1:0] sz;
            logic [63:0] a, wd;
            cur = 1000 * (k + 1) + i;
            w = 1'($urandom_range(0, 1));
            u = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a = {$urandom, $urandom};
            if ($urandom_range(0, 9) < 7) a = a & ~((64'd1 << sz) - 64'd1);
            wd = {$urandom, $urandom};
            xact(k, w, a, wd, sz, u, $urandom_range(0, 2));
            model_check(k, w, a, wd, sz, u);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
